// File: rtl/arbitro_planificador.sv
// Two-VC weighted arbiter: picks one source VC per cycle toward a non-paused destination.
// Optional anti-starvation guard for VC1 is enabled with macro ARB_STARVATION_GUARD_EN.
module arbitro_planificador #(
    parameter int WEIGHT = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       arb_enable,
    input  logic       VC0_empty,
    input  logic       VC1_empty,
    input  logic       VC0_dest,
    input  logic       VC1_dest,
    input  logic       D0_pause,
    input  logic       D1_pause,
    output logic       VC0_pop,
    output logic       VC1_pop,
    output logic       valid_out,
    output logic       vc_sel,
    output logic       dest_out,
    output logic [1:0] arb_state,
    output logic [2:0] starve_cnt
);

    if (WEIGHT < 1 || WEIGHT > 7) begin : g_weight_chk
        $error("arbitro_planificador: WEIGHT must be in 1..7");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   valid_q, valid_d;
    logic   sel_q,   sel_d;
    logic   dest_q,  dest_d;
    logic   elig0, elig1;
    logic   guard_fire;
    logic   gnt0, gnt1;

    // Pause is checked against the head word's own destination, so a blocked
    // VC never stalls the other one.
    assign elig0 = !VC0_empty && !(VC0_dest ? D1_pause : D0_pause);
    assign elig1 = !VC1_empty && !(VC1_dest ? D1_pause : D0_pause);

`ifdef ARB_STARVATION_GUARD_EN
    localparam logic [2:0] WEIGHT_C = 3'(WEIGHT);
    logic [2:0] starve_q, starve_d;

    assign guard_fire = (starve_q == WEIGHT_C) && elig1;

    always_comb begin
        starve_d = starve_q;
        if (arb_enable) begin
            if (gnt1 || !elig1)
                starve_d = 3'd0;
            else if (gnt0 && starve_q != WEIGHT_C)
                starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) starve_q <= 3'd0;
        else          starve_q <= starve_d;
    end

    assign starve_cnt = starve_q;
`else
    assign guard_fire = 1'b0;
    assign starve_cnt = 3'd0;
`endif

    // Grant and next state are decided in one place so the pops and the
    // registered view can never disagree.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = IDLE;
        valid_d = 1'b0;
        sel_d   = sel_q;
        dest_d  = dest_q;
        if (reset_L && arb_enable) begin
            if (guard_fire)  gnt1 = 1'b1;
            else if (elig0)  gnt0 = 1'b1;
            else if (elig1)  gnt1 = 1'b1;
        end
        if (gnt0) begin
            state_d = GNT0;
            valid_d = 1'b1;
            sel_d   = 1'b0;
            dest_d  = VC0_dest;
        end else if (gnt1) begin
            state_d = GNT1;
            valid_d = 1'b1;
            sel_d   = 1'b1;
            dest_d  = VC1_dest;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            dest_q  <= dest_d;
        end
    end

    assign VC0_pop   = gnt0;
    assign VC1_pop   = gnt1;
    assign valid_out = valid_q;
    assign vc_sel    = sel_q;
    assign dest_out  = dest_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_arbitro_planificador.sv
// Bench for arbitro_planificador: directed scenarios then random traffic,
// all checked against a rule-level reference model.
module tb_arbitro_planificador;
    localparam int WEIGHT = 4;
`ifdef ARB_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L, arb_enable;
    logic       VC0_empty, VC1_empty, VC0_dest, VC1_dest, D0_pause, D1_pause;
    logic       VC0_pop, VC1_pop, valid_out, vc_sel, dest_out;
    logic [1:0] arb_state;
    logic [2:0] starve_cnt;

    always #5 clk = ~clk;

    arbitro_planificador #(.WEIGHT(WEIGHT)) dut (
        .clk(clk), .reset_L(reset_L), .arb_enable(arb_enable),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .VC0_dest(VC0_dest), .VC1_dest(VC1_dest),
        .D0_pause(D0_pause), .D1_pause(D1_pause),
        .VC0_pop(VC0_pop), .VC1_pop(VC1_pop),
        .valid_out(valid_out), .vc_sel(vc_sel), .dest_out(dest_out),
        .arb_state(arb_state), .starve_cnt(starve_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    // Reference model: last registered view plus count of VC0 wins in a row while VC1 waited.
    int m_valid, m_sel, m_dest, m_state, m_starve;
    int m_g;
    int obs_p1;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic bit elig(input logic empty, input logic dest);
        return !empty && !(dest ? D1_pause : D0_pause);
    endfunction

    function automatic int model_grant();
        if (!reset_L || !arb_enable) return -1;
        if (GUARD && m_starve == WEIGHT && elig(VC1_empty, VC1_dest)) return 1;
        if (elig(VC0_empty, VC0_dest)) return 0;
        if (elig(VC1_empty, VC1_dest)) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_sel = 0; m_dest = 0; m_state = 0; m_starve = 0;
    endtask

    task automatic drive(input logic e0, input logic e1, input logic d0, input logic d1,
                         input logic p0, input logic p1, input logic en);
        VC0_empty = e0; VC1_empty = e1; VC0_dest = d0; VC1_dest = d1;
        D0_pause = p0; D1_pause = p1; arb_enable = en;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".valid"}, 4'(valid_out),  4'(m_valid));
        chk({tag, ".sel"},   4'(vc_sel),     4'(m_sel));
        chk({tag, ".dest"},  4'(dest_out),   4'(m_dest));
        chk({tag, ".state"}, 4'(arb_state),  4'(m_state));
        chk({tag, ".starve"},4'(starve_cnt), 4'(m_starve));
    endtask

    // One clock: check pops mid-cycle, advance the model on the edge, check registers.
    task automatic cycle(input string tag);
        bit e1;
        @(negedge clk);
        m_g = model_grant();
        e1  = elig(VC1_empty, VC1_dest);
        chk({tag, ".pop0"}, 4'(VC0_pop), 4'(m_g == 0));
        chk({tag, ".pop1"}, 4'(VC1_pop), 4'(m_g == 1));
        obs_p1 = int'(VC1_pop);
        if (GUARD && arb_enable) begin
            if (m_g == 1 || !e1) m_starve = 0;
            else if (m_g == 0 && m_starve < WEIGHT) m_starve++;
        end
        if (m_g >= 0) begin
            m_valid = 1;
            m_sel   = m_g;
            m_dest  = (m_g == 1) ? int'(VC1_dest) : int'(VC0_dest);
            m_state = m_g + 1;
        end else begin
            m_valid = 0;
            m_state = 0;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        int cnt1;
        reset_L = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #12;
        chk("rst.pop0", 4'(VC0_pop), 4'd0);
        chk("rst.pop1", 4'(VC1_pop), 4'd0);
        check_regs("rst");
        @(posedge clk); #1;
        reset_L = 1'b1;

        // VC0-only stream toward D0, then idle
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle("vc0burst");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("idle");
        chk("idle.hold_dest", 4'(dest_out), 4'd0);

        // Both eligible: weighted pattern with the guard, strict VC0 otherwise
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cnt1 = 0;
        for (int i = 0; i < 10; i++) begin
            cycle("both");
            cnt1 += obs_p1;
        end
        chk("both.vc1_count", 4'(cnt1), GUARD ? 4'd2 : 4'd0);

        // VC0 head blocked by D1 pause: VC1 wins, release gives VC0 at once
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle("paused");
        chk("paused.pop1", 4'(obs_p1), 4'd1);
        D1_pause = 1'b0;
        cycle("released");

        // Enable toggling
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("flush");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("en1");
        arb_enable = 1'b0;
        cycle("en0");
        arb_enable = 1'b1;
        cycle("en1b");

        // Reset in the middle of a VC1 burst
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("vc1burst");
        cycle("vc1burst");
        #3;
        reset_L = 1'b0;
        #1;
        model_reset();
        chk("midrst.pop1", 4'(VC1_pop), 4'd0);
        chk("midrst.pop0", 4'(VC0_pop), 4'd0);
        check_regs("midrst");
        @(posedge clk); #1;
        check_regs("inrst");
        reset_L = 1'b1;
        cycle("postrst");

        // Both empty, then VC1 becomes non-empty
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("empty");
        cycle("empty");
        VC1_empty = 1'b0;
        cycle("vc1arrive");
        chk("vc1arrive.sel", 4'(vc_sel), 4'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3) == 0, $urandom_range(3) == 0,
                  1'($urandom), 1'($urandom),
                  $urandom_range(4) == 0, $urandom_range(4) == 0,
                  $urandom_range(9) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_planificador.md
ARBITRO_PLANIFICADOR -- requirements
Module: arbitro_planificador

Interface
REQ-001 Parameter WEIGHT, default 4, is the maximum number of consecutive VC0 grants while VC1 is eligible; legal range 1..7.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 arb_enable  input  1  high permits grants; low blocks all grants.
REQ-005 VC0_empty, VC1_empty  input  1 each  source VC FIFO empty flags.
REQ-006 VC0_dest, VC1_dest  input  1 each  destination of the VC head word: 0 selects D0, 1 selects D1.
REQ-007 D0_pause, D1_pause  input  1 each  destination FIFO almost-full backpressure.
REQ-008 VC0_pop, VC1_pop  output  1 each  combinational pop strobes to the source FIFOs.
REQ-009 valid_out  output  1  registered; popped word is present on the FIFO read data this cycle.
REQ-010 vc_sel  output  1  registered; VC popped in the previous cycle (0 = VC0, 1 = VC1), drives the data mux select.
REQ-011 dest_out  output  1  registered; destination of the popped word, drives the demux select.
REQ-012 arb_state  output  2  registered FSM state: 0 = IDLE, 1 = GNT0, 2 = GNT1.
REQ-013 starve_cnt  output  3  registered anti-starvation count.

Function
REQ-014 elig0 SHALL be !VC0_empty & !(VC0_dest ? D1_pause : D0_pause); elig1 is defined the same way for VC1.
REQ-015 Grant priority SHALL be evaluated in this order; the first match wins:
- (a) arb_enable=0 or reset_L=0: no grant.
- (b) starvation guard fires (REQ-024): VC1.
- (c) elig0: VC0.
- (d) elig1: VC1.
- (e) otherwise: no grant.
REQ-016 VC0_pop SHALL equal (grant == VC0) in the same cycle, and VC1_pop SHALL equal (grant == VC1), with zero latency.
REQ-017 At most one of VC0_pop and VC1_pop SHALL be high in any cycle.
REQ-018 On the clock edge after a grant, the block SHALL set:
- valid_out = 1;
- vc_sel = the granted VC;
- dest_out = the granted VC's dest, sampled at the grant cycle.
REQ-019 On the clock edge after a cycle with no grant, valid_out SHALL be 0, and vc_sel and dest_out SHALL hold their values.
REQ-020 FSM next state SHALL be:
- GNT0 on a VC0 grant;
- GNT1 on a VC1 grant;
- IDLE on no grant.
This applies from any state.
REQ-021 A pause asserted in the same cycle as a grant evaluation SHALL block that grant (no one-cycle lag).
REQ-022 Back-to-back grants to the same VC on every cycle SHALL be permitted while it remains eligible.

Reset
REQ-023 While reset_L=0, asynchronously, the block SHALL force:
- VC0_pop = 0 and VC1_pop = 0;
- valid_out = 0, vc_sel = 0, dest_out = 0;
- arb_state = IDLE, starve_cnt = 0.
On reset_L=0 mid-burst, the pops drop immediately and no partial grant is registered.

Configuration
REQ-024 With macro ARB_STARVATION_GUARD_EN defined:
- starve_cnt increments (saturating at WEIGHT) on each VC0 grant while elig1=1;
- starve_cnt clears to 0 on a VC1 grant or in any cycle with elig1=0;
- starve_cnt holds when arb_enable=0;
- the guard fires when starve_cnt == WEIGHT and elig1=1.
REQ-025 Without ARB_STARVATION_GUARD_EN, arbitration SHALL be strict VC0 priority, starve_cnt SHALL be tied to 0, and no counter logic is synthesized.

Verification
REQ-026 VC0 non-empty (dest 0), VC1 empty, pauses 0, enable 1 for 5 cycles -> VC0_pop high for 5 cycles; valid_out high from cycle 2 to cycle 6 with vc_sel=0 and dest_out=0.
REQ-027 Guard enabled, WEIGHT=4, both VCs eligible for 10 cycles -> pop pattern VC0,VC0,VC0,VC0,VC1,VC0,VC0,VC0,VC0,VC1; without the guard -> VC0 on all 10 cycles.
REQ-028 VC0_dest=1, D1_pause=1, VC1 eligible toward D0 -> VC1_pop=1, VC0_pop=0; releasing D1_pause -> VC0_pop=1 in the same cycle.
REQ-029 Both VCs eligible, arb_enable toggled 1,0,1 -> pops 1,0,1; starve_cnt holds through the disabled cycle; arb_state goes GNT0 -> IDLE -> GNT0.
REQ-030 reset_L driven low mid-cycle during a VC1 burst -> VC1_pop=0 immediately, all registered outputs 0, arb_state=IDLE; after release with VC1 still eligible -> VC1_pop=1 on the first enabled cycle.
REQ-031 Both FIFOs empty -> no pops and valid_out=0; VC1_empty falling in cycle N -> VC1_pop=1 in cycle N and valid_out=1 with vc_sel=1 in cycle N+1.
